// File: rtl/spi_dac_pkg.sv
// Shared types and constants for the quad-DAC SPI master.
package spi_dac_pkg;
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_e;

    localparam int          FRAME_W    = 32;
    localparam logic [3:0]  CMD_WR_UPD = 4'h3;
    localparam logic [3:0]  CMD_WR     = 4'h0;
    localparam logic [31:0] DEF_SETUP  = 32'h08000001;
endpackage

// File: rtl/spi_dac_fifo.sv
// Synchronous first-word-fall-through request FIFO; dout shows the head whenever !empty.
module spi_dac_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/spi_dac_mc.sv
// Multi-channel SPI master for a 12-bit quad DAC: SETUP word after reset, then queued frames.
// Optional feature macro SPI_DAC_MC_LDAC_EN: write-only frames plus a shared ldac_n update pulse.
module spi_dac_mc
    import spi_dac_pkg::*;
#(
    parameter int          DW      = 12,
    parameter int          NCH     = 4,
    parameter int          CH_W    = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int          DEPTH   = 8,
    parameter int          CLK_DIV = 50,
    parameter int          CS_GAP  = 4,
    parameter logic [31:0] SETUP   = DEF_SETUP
) (
    input  logic            clk100mhz,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH_W-1:0] in_chan,
    input  logic [DW-1:0]   in_data,
    output logic            cs,
    output logic            sclk,
    output logic            mosi,
    output logic            done,
`ifdef SPI_DAC_MC_LDAC_EN
    output logic            ldac_n,
`endif
    output logic            busy
);
    localparam int PW = $clog2(2 * CLK_DIV);
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
`ifdef SPI_DAC_MC_LDAC_EN
    localparam logic [3:0] CMD = CMD_WR;
`else
    localparam logic [3:0] CMD = CMD_WR_UPD;
`endif

    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  shreg_q, shreg_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [5:0]          bit_q, bit_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [CH_W+DW-1:0]  req_q, req_d;
    logic                cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic                done_q, done_d, busy_q, busy_d, init_q, init_d;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CH_W+DW-1:0]  fifo_dout;
    logic [CH_W-1:0]     req_chan;
    logic [19:0]         data20;
    logic [FRAME_W-1:0]  frame;

    assign in_ready  = init_q && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    spi_dac_fifo #(.W(CH_W + DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk100mhz),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({in_chan, in_data}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign req_chan = req_q[CH_W+DW-1:DW];
    assign data20   = 20'(req_q[DW-1:0]) << (20 - DW);
    assign frame    = {4'h0, CMD, 4'(req_chan), data20};

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            state_q <= S_INIT;
            shreg_q <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            req_q   <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            req_q   <= req_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            init_q  <= init_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        req_d    = req_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        init_d   = init_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            S_INIT: begin
                shreg_d = SETUP;
                cs_d    = 1'b0;
                mosi_d  = SETUP[31];
                phase_d = '0;
                bit_d   = '0;
                state_d = S_SHIFT;
            end
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    req_d    = fifo_dout;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                // Out-of-range channels are consumed without touching the bus.
                if (int'(req_chan) < NCH) begin
                    shreg_d = frame;
                    cs_d    = 1'b0;
                    mosi_d  = frame[31];
                    phase_d = '0;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                // One extra sclk-low cycle after the 32nd fall gives cs hold time.
                if (bit_q == 6'd32) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    gap_d   = '0;
                    done_d  = init_q;
                    state_d = S_GAP;
                end else if (phase_q == PW'(2 * CLK_DIV - 1)) begin
                    phase_d = '0;
                    sclk_d  = 1'b0;
                    shreg_d = shreg_q << 1;
                    mosi_d  = shreg_d[31];
                    bit_d   = bit_q + 6'd1;
                end else begin
                    phase_d = phase_q + 1'b1;
                    if (phase_q == PW'(CLK_DIV - 1)) sclk_d = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(CS_GAP - 1)) begin
                    init_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
        busy_d = (state_d != S_IDLE) || !fifo_empty || fifo_push;
    end

`ifdef SPI_DAC_MC_LDAC_EN
    logic [1:0] ldac_cnt_q;

    always_ff @(posedge clk100mhz) begin
        if (rst)                      ldac_cnt_q <= '0;
        else if (done_d && fifo_empty) ldac_cnt_q <= 2'd2;
        else if (ldac_cnt_q != '0)    ldac_cnt_q <= ldac_cnt_q - 2'd1;
    end

    assign ldac_n = (ldac_cnt_q == '0);
`endif

    assign cs   = cs_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign done = done_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_spi_dac_mc.sv
// Self-checking bench for spi_dac_mc: SPI bus monitor, frame-list reference model, vector table.
module tb_spi_dac_mc;
    localparam int          DW      = 12;
    localparam int          NCH     = 4;
    localparam int          CH_W    = 3;   // wide enough to present out-of-range channels
    localparam int          DEPTH   = 8;
    localparam int          CLK_DIV = 4;
    localparam int          CS_GAP  = 4;
    localparam logic [31:0] SETUP   = 32'h08000001;
    localparam int          CS_LOW  = 1 + 64 * CLK_DIV;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [CH_W-1:0] in_chan = '0;
    logic [DW-1:0]   in_data = '0;
    logic            in_ready, cs, sclk, mosi, done, busy;

    always #5 clk = ~clk;

    spi_dac_mc #(
        .DW(DW), .NCH(NCH), .CH_W(CH_W), .DEPTH(DEPTH),
        .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .SETUP(SETUP)
    ) dut (
        .clk100mhz (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_chan   (in_chan),
        .in_data   (in_data),
        .cs        (cs),
        .sclk      (sclk),
        .mosi      (mosi),
        .done      (done),
        .busy      (busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] frames[$];
    int          lens[$];
    logic [31:0] exp_q[$];

    int          ndone = 0, ncsfall = 0, viol = 0, nb = 0;
    int          lowlen = 0, hilen = 1000000, min_gap = 1000000;
    logic [31:0] sh = '0;
    logic        cs_p = 1'b1, sclk_p = 1'b0, mosi_p = 1'b0;

    // Bus monitor: decodes frames on sclk rise and checks bus discipline.
    always @(negedge clk) begin
        if (cs_p === 1'b1 && cs === 1'b0) begin
            ncsfall++;
            sh = '0;
            nb = 0;
            lowlen = 0;
            if (hilen < min_gap) min_gap = hilen;
        end
        if (cs === 1'b0) begin
            lowlen++;
            if (sclk === 1'b1 && sclk_p === 1'b0) begin
                sh = {sh[30:0], mosi};
                nb++;
            end
            if (sclk === 1'b1 && sclk_p === 1'b1 && mosi !== mosi_p) viol++;
        end else begin
            hilen++;
            if (sclk === 1'b1) viol++;
        end
        if (cs_p === 1'b0 && cs === 1'b1) begin
            if (nb == 32) begin
                frames.push_back(sh);
                lens.push_back(lowlen);
            end
            hilen = 0;
        end
        if (done === 1'b1) ndone++;
        cs_p = cs;
        sclk_p = sclk;
        mosi_p = mosi;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_frame(input int ch, input int d);
        return (32'h03 << 24) | (32'(ch) << 20) | (32'(d) << (20 - DW));
    endfunction

    task automatic model_add(input int ch, input int d);
        if (ch < NCH) exp_q.push_back(model_frame(ch, d));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_cs", cs, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        frames.delete();
        lens.delete();
        exp_q.delete();
        exp_q.push_back(SETUP);
        ndone = 0;
        ncsfall = 0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy !== 1'b0 || cs !== 1'b1) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0 || cs !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: busy=%b cs=%b after %0d cycles, expected idle", busy, cs, n);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int ch, input int d);
        int n = 0;
        in_valid = 1'b1;
        in_chan = CH_W'(ch);
        in_data = DW'(d);
        while (in_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send(input int ch, input int d);
        push(ch, d);
        model_add(ch, d);
    endtask

    task automatic check_frames(input string tag);
        int n;
        chk({tag, "_nframes"}, frames.size(), exp_q.size());
        n = (frames.size() < exp_q.size()) ? frames.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_frame%0d", tag, i), frames[i], exp_q[i]);
            chk($sformatf("%s_cslen%0d", tag, i), lens[i], CS_LOW);
        end
        frames.delete();
        lens.delete();
        exp_q.delete();
    endtask

    typedef struct {
        int          ch;
        int          d;
        logic [31:0] fr;
        int          sent;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n, k;
        tbl[0] = '{0, 'hAAA, 32'h030AAA00, 1};
        tbl[1] = '{1, 'h555, 32'h03155500, 1};
        tbl[2] = '{3, 'hFFF, 32'h033FFF00, 1};
        tbl[3] = '{2, 'h001, 32'h03200100, 1};
        tbl[4] = '{5, 'h123, 32'h0,        0};
        tbl[5] = '{4, 'h456, 32'h0,        0};
        tbl[6] = '{7, 'hABC, 32'h0,        0};
        tbl[7] = '{0, 'h000, 32'h03000000, 1};

        // Reset release with no requests: SETUP only, no done.
        do_reset();
        repeat (5) @(negedge clk);
        chk("init_ready_low", in_ready, 0);
        wait_idle(5000);
        chk("setup_ready", in_ready, 1);
        chk("setup_done", ndone, 0);
        check_frames("setup");

        // Acceptance-to-cs latency, done pulse and busy tail.
        in_valid = 1'b1;
        in_chan = 3'd2;
        in_data = 12'h5A5;
        chk("lat_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        model_add(2, 'h5A5);
        chk("lat_cs_n0", cs, 1);
        @(negedge clk);
        chk("lat_cs_n1", cs, 1);
        @(negedge clk);
        chk("lat_cs_n2", cs, 0);
        n = 0;
        while (cs !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("lat_done_pulse", done, 1);
        k = 0;
        while (busy === 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("busy_tail", k, CS_GAP);
        wait_idle(1000);
        check_frames("lat");

        // Vector table: single requests including out-of-range channels.
        for (int i = 0; i < 8; i++) begin
            ndone = 0;
            ncsfall = 0;
            frames.delete();
            lens.delete();
            push(tbl[i].ch, tbl[i].d);
            wait_idle(2000);
            chk($sformatf("tbl%0d_nframes", i), frames.size(), tbl[i].sent);
            if (tbl[i].sent == 1 && frames.size() > 0) chk($sformatf("tbl%0d_frame", i), frames[0], tbl[i].fr);
            chk($sformatf("tbl%0d_done", i), ndone, tbl[i].sent);
            chk($sformatf("tbl%0d_csfall", i), ncsfall, tbl[i].sent);
        end
        frames.delete();
        lens.delete();

        // Back-to-back channels 0..3.
        ndone = 0;
        min_gap = 1000000;
        send(0, 'h111);
        send(1, 'h222);
        send(2, 'h333);
        send(3, 'h444);
        wait_idle(5000);
        check_frames("b2b");
        chk("b2b_done", ndone, 4);
        chk("b2b_gap_ok", (min_gap >= CS_GAP) ? 1 : 0, 1);

        // Nine requests pushed during init: ready low until SETUP, then FIFO fills.
        do_reset();
        repeat (3) @(negedge clk);
        chk("init9_ready_low", in_ready, 0);
        for (int i = 0; i < 9; i++) send(i % NCH, 'h100 + i);
        chk("full_ready_low", in_ready, 0);
        wait_idle(20000);
        check_frames("init9");

        // Reset in the middle of a data frame with another request queued.
        send(1, 'h321);
        send(2, 'h654);
        n = 0;
        while (!(nb == 17 && cs === 1'b0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_bit17_reached", nb, 17);
        do_reset();
        wait_idle(5000);
        chk("mid_done", ndone, 0);
        check_frames("mid");

        // Randomized traffic against the frame-list model.
        ndone = 0;
        k = 0;
        for (int i = 0; i < 25; i++) begin
            int ch, d;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ch = $urandom_range(0, 7);
            d  = $urandom & 'hFFF;
            if (ch < NCH) k++;
            send(ch, d);
        end
        wait_idle(30000);
        chk("rand_done", ndone, k);
        check_frames("rand");

        chk("bus_protocol", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
